// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the 8-bit pipelined core. It detects load-use
//   hazards and taken-branch flushes combinationally, and runs the
//   multi-cycle interrupt entry (drain -> push PC/save CCR -> vector) and
//   RET/RTI return-address wait sequences.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   idex_memread    EX holds a load/pop
//   idex_dist       EX destination register
//   ifid_ra/rb      ID source registers, ifid_uses_rb qualifies rb
//   id_is_ret/rti   ID holds RET / RTI
//   branch_taken    EX resolved a taken branch/jump/call
//   intr            level interrupt request
//   pc_en, ifid_en, ifid_flush, idex_flush   pipeline register controls
//   int_push, copy_ccr, paste_ccr, vec_sel   interrupt/return datapath controls
//   int_ack         one-cycle interrupt acknowledge
//   busy            sequencer is not in RUN
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int RET_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idex_memread,
  input  logic [1:0] idex_dist,
  input  logic [1:0] ifid_ra,
  input  logic [1:0] ifid_rb,
  input  logic       ifid_uses_rb,
  input  logic       id_is_ret,
  input  logic       id_is_rti,
  input  logic       branch_taken,
  input  logic       intr,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       int_push,
  output logic       copy_ccr,
  output logic       paste_ccr,
  output logic       vec_sel,
  output logic       int_ack,
  output logic       busy
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    INT_DRAIN = 3'd1,
    INT_PUSH  = 3'd2,
    INT_VEC   = 3'd3,
    RET_WAIT  = 3'd4
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
  localparam logic [2:0] RET_LOAD   = 3'(RET_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       rti_q, rti_d;
  logic       load_use;
  logic       int_req;

  // Only a load in EX can create a hazard; rb matters only when ID reads it.
  assign load_use = idex_memread &&
                    ((idex_dist == ifid_ra) ||
                     (ifid_uses_rb && (idex_dist == ifid_rb)));

  // A request seen this cycle is acted on immediately in RUN, so a one-cycle
  // pulse enters the drain on the very next edge.
  assign int_req = pend_q | intr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
      rti_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rti_q   <= rti_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q | intr;
    rti_d      = rti_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    int_push   = 1'b0;
    copy_ccr   = 1'b0;
    paste_ccr  = 1'b0;
    vec_sel    = 1'b0;
    int_ack    = 1'b0;
    busy       = (state_q != RUN);

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          // Wrong-path ID/EX contents are dropped, including any RET or
          // stalled instruction; a pending interrupt waits one more cycle.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (int_req) begin
          ifid_flush = 1'b1;
          pc_en      = 1'b0;
          state_d    = INT_DRAIN;
          cnt_d      = DRAIN_LOAD;
        end else if (id_is_ret || id_is_rti) begin
          ifid_flush = 1'b1;
          pc_en      = 1'b0;
          state_d    = RET_WAIT;
          cnt_d      = RET_LOAD;
          rti_d      = id_is_rti;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      INT_DRAIN: begin
        // A branch still retiring in EX must be allowed to redirect PC so the
        // pushed return address is correct.
        ifid_flush = 1'b1;
        pc_en      = branch_taken;
        idex_flush = branch_taken;
        if (cnt_q == 3'd0) state_d = INT_PUSH;
        else               cnt_d   = cnt_q - 3'd1;
      end
      INT_PUSH: begin
        int_push   = 1'b1;
        copy_ccr   = 1'b1;
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        state_d    = INT_VEC;
      end
      INT_VEC: begin
        vec_sel    = 1'b1;
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        int_ack    = 1'b1;
        pend_d     = 1'b0;
        state_d    = RUN;
      end
      RET_WAIT: begin
        ifid_flush = 1'b1;
        pc_en      = branch_taken;
        idex_flush = branch_taken;
        if (cnt_q == 3'd0) begin
          pc_en     = 1'b1;
          paste_ccr = rti_q;
          state_d   = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset dominates everything: hold the front end cleared and emit no
    // push/paste side effects.
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      int_push   = 1'b0;
      copy_ccr   = 1'b0;
      paste_ccr  = 1'b0;
      vec_sel    = 1'b0;
      int_ack    = 1'b0;
      busy       = 1'b0;
      state_d    = RUN;
      cnt_d      = 3'd0;
      pend_d     = 1'b0;
      rti_d      = 1'b0;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central pipeline sequencer for the 8-bit pipelined core; drives the PC enable, IF/ID enable/flush and ID/EX flush.
- Detects load-use hazards and taken-branch flushes combinationally.
- Runs multi-cycle sequences for external interrupts (drain, push PC, save CCR, vector) and RET/RTI (stall fetch until the return address arrives, restore CCR on RTI).
- Sits beside the decode stage; consumes ID/EX and EX status.

Parameters:
- DRAIN_CYCLES, 3, bubble cycles inserted before an interrupt push so in-flight instructions retire; range 1-7.
- RET_CYCLES, 3, fetch-stall cycles after RET/RTI leaves ID, until the popped PC is valid; range 1-7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- idex_memread  in  1  instruction in EX is a load/pop
- idex_dist  in  2  destination register of instruction in EX
- ifid_ra  in  2  source A of instruction in ID
- ifid_rb  in  2  source B of instruction in ID
- ifid_uses_rb  in  1  ID instruction reads source B
- id_is_ret  in  1  ID holds RET
- id_is_rti  in  1  ID holds RTI
- branch_taken  in  1  EX resolved a taken branch/jump/call
- intr  in  1  external interrupt request, level
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear
- idex_flush  out  1  ID/EX clear (drives Flush)
- int_push  out  1  force push of PC onto stack (SP via R3)
- copy_ccr  out  1  save CCR
- paste_ccr  out  1  restore CCR
- vec_sel  out  1  PC mux selects interrupt vector M[1]
- int_ack  out  1  one-cycle interrupt acknowledge
- busy  out  1  state != RUN

Behaviour:
- States: RUN, INT_DRAIN, INT_PUSH, INT_VEC, RET_WAIT. Uses a 3-bit down-counter cnt and a pend flag.
- Reset, while rst=1:
  - pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1; every other output 0.
  - Next state RUN, cnt=0, pend=0.
- pend: set when intr=1 in any cycle; cleared in INT_VEC. A request arriving during INT_DRAIN/PUSH/VEC is re-latched only if intr is still high after INT_VEC.
- Defaults (RUN, no event): pc_en=1, ifid_en=1, all others 0. Outputs are combinational from state and inputs.
- RUN priority: branch_taken > pend > id_is_ret|id_is_rti > load-use.
  - branch_taken: ifid_flush=1, idex_flush=1, pc_en=1. Stay RUN; any RET or load-use in ID is discarded.
  - pend: ifid_flush=1, pc_en=0. Go to INT_DRAIN with cnt=DRAIN_CYCLES-1.
  - RET/RTI: the instruction proceeds into ID/EX; ifid_flush=1, pc_en=0. Go to RET_WAIT with cnt=RET_CYCLES-1; latch is_rti.
  - load-use: true when idex_memread and idex_dist==ifid_ra, or ifid_uses_rb and idex_dist==ifid_rb. Drive pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle. The next cycle re-evaluates, and the load has then left EX.
- INT_DRAIN:
  - ifid_flush=1, pc_en=branch_taken, so a late branch still updates PC.
  - If branch_taken, also idex_flush=1.
  - cnt==0 -> INT_PUSH, else cnt-1.
- INT_PUSH (1 cycle): int_push=1, copy_ccr=1, pc_en=0, ifid_flush=1 -> INT_VEC.
- INT_VEC (1 cycle): vec_sel=1, pc_en=1, ifid_flush=1, int_ack=1; pend cleared -> RUN.
- RET_WAIT:
  - pc_en=0, ifid_flush=1.
  - On cnt==0: pc_en=1 (PC loads popped address); paste_ccr=1 if is_rti -> RUN. Else cnt-1.
  - branch_taken during RET_WAIT: flush both registers, pc_en=1; the sequence continues.
- busy=1 in every non-RUN state.
- pend is ignored during RET_WAIT; it is serviced on return to RUN.
- Reset mid-sequence aborts immediately to RUN; no push or paste pulse is emitted.

Test Plan:
- Load-use: idex_memread=1, idex_dist=2, ifid_ra=2 for one cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle (memread=0) all defaults.
- Rb gating: idex_dist=1, ifid_rb=1, ifid_uses_rb=0 -> no stall; same with ifid_uses_rb=1 -> stall.
- Branch priority: branch_taken=1 with id_is_ret=1 and a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1, state stays RUN, busy=0.
- Interrupt with DRAIN_CYCLES=3, intr pulsed one cycle in RUN:
  - Cycles 1-3: INT_DRAIN with ifid_flush=1.
  - Cycle 4: int_push=1 and copy_ccr=1.
  - Cycle 5: vec_sel=1 and int_ack=1.
  - Cycle 6: RUN.
- RTI with RET_CYCLES=3: id_is_rti=1 -> 2 cycles with pc_en=0, then a cycle with pc_en=1 and paste_ccr=1, then RUN. Repeat with RET: paste_ccr stays 0.
- Reset during INT_DRAIN at cnt=1 -> next cycle RUN, and int_push never asserted.
